// File: rtl/vend_controller.sv
// vend_controller: credit accumulator, price check, dispense strobe and change/refund handshake.
// Optional inactivity refund while collecting is compiled in with `define VEND_TIMEOUT_EN.
module vend_controller #(
  parameter int CURRENCY_WIDTH = 7,
  parameter int PRICE0         = 15,
  parameter int PRICE1         = 25,
  parameter int PRICE2         = 30,
  parameter int PRICE3         = 40,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CURRENCY_WIDTH-1:0] coin_value,
  input  logic                      coin_valid,
  output logic                      coin_ready,
  output logic                      coin_reject,
  input  logic [1:0]                sel_item,
  input  logic                      sel_valid,
  output logic                      sel_denied,
  input  logic                      cancel,
  output logic [CURRENCY_WIDTH-1:0] credit,
  output logic                      dispense,
  output logic [1:0]                dispense_item,
  output logic [CURRENCY_WIDTH-1:0] change_value,
  output logic                      change_valid,
  input  logic                      change_ack,
  output logic                      busy
);
  localparam int CW = CURRENCY_WIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] credit_reg, credit_next;
  logic [CW-1:0] change_value_reg, change_value_next;
  logic [1:0]    dispense_item_reg, dispense_item_next;
  logic          coin_reject_reg, coin_reject_next;
  logic          sel_denied_reg, sel_denied_next;
  logic          dispense_reg, change_valid_reg, busy_reg, coin_ready_reg;
  logic [CW-1:0] sel_price;
  logic [CW:0]   coin_sum;
  logic          in_collect, sel_take, refund_now, coin_credit, timeout_hit;

  // One extra bit so an overflowing coin is detected rather than wrapped.
  assign coin_sum   = {1'b0, credit_reg} + {1'b0, coin_value};
  assign in_collect = (state_reg == COLLECT);
  assign sel_take   = in_collect && sel_valid && (credit_reg >= sel_price);
  assign refund_now = in_collect && (cancel || (timeout_hit && !sel_take));

  always_comb begin
    case (sel_item)
      2'd0:    sel_price = CW'(PRICE0);
      2'd1:    sel_price = CW'(PRICE1);
      2'd2:    sel_price = CW'(PRICE2);
      default: sel_price = CW'(PRICE3);
    endcase
  end

  always_comb begin
    state_next         = state_reg;
    credit_next        = credit_reg;
    change_value_next  = change_value_reg;
    dispense_item_next = dispense_item_reg;
    coin_reject_next   = 1'b0;
    sel_denied_next    = 1'b0;
    coin_credit        = 1'b0;
    case (state_reg)
      IDLE, COLLECT: begin
        if (refund_now) begin
          state_next        = CHANGE;
          change_value_next = credit_reg;
          credit_next       = '0;
          coin_reject_next  = coin_valid;
          sel_denied_next   = sel_valid;
        end else if (sel_take) begin
          state_next         = DISPENSE;
          credit_next        = credit_reg - sel_price;
          dispense_item_next = sel_item;
          coin_reject_next   = coin_valid;
        end else begin
          sel_denied_next = sel_valid;
          if (coin_valid && (coin_value != '0)) begin
            if (!coin_sum[CW]) begin
              credit_next = coin_sum[CW-1:0];
              state_next  = COLLECT;
              coin_credit = 1'b1;
            end else begin
              coin_reject_next = 1'b1;
            end
          end
        end
      end
      DISPENSE: begin
        coin_reject_next = coin_valid;
        sel_denied_next  = sel_valid;
        credit_next      = '0;
        if (credit_reg != '0) begin
          state_next        = CHANGE;
          change_value_next = credit_reg;
        end else begin
          state_next = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_next = coin_valid;
        sel_denied_next  = sel_valid;
        if (change_ack) begin
          state_next        = IDLE;
          change_value_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      credit_reg        <= '0;
      change_value_reg  <= '0;
      dispense_item_reg <= 2'd0;
      coin_reject_reg   <= 1'b0;
      sel_denied_reg    <= 1'b0;
      dispense_reg      <= 1'b0;
      change_valid_reg  <= 1'b0;
      busy_reg          <= 1'b0;
      coin_ready_reg    <= 1'b1;
    end else begin
      state_reg         <= state_next;
      credit_reg        <= credit_next;
      change_value_reg  <= change_value_next;
      dispense_item_reg <= dispense_item_next;
      coin_reject_reg   <= coin_reject_next;
      sel_denied_reg    <= sel_denied_next;
      dispense_reg      <= (state_next == DISPENSE);
      change_valid_reg  <= (state_next == CHANGE);
      busy_reg          <= (state_next != IDLE);
      coin_ready_reg    <= (state_next == IDLE) || (state_next == COLLECT);
    end
  end

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_reg;

  assign timeout_hit = in_collect && (idle_cnt_reg == TW'(TIMEOUT_CYCLES - 1));

  // Entry to COLLECT is always via a credited coin, so clearing on credit covers both cases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              idle_cnt_reg <= '0;
    else if (coin_credit) idle_cnt_reg <= '0;
    else if (in_collect)  idle_cnt_reg <= idle_cnt_reg + 1'b1;
    else                  idle_cnt_reg <= '0;
  end
`else
  logic unused_cfg;
  assign timeout_hit = 1'b0;
  assign unused_cfg  = coin_credit ^ (TIMEOUT_CYCLES == 0);
`endif

  assign credit        = credit_reg;
  assign change_value  = change_value_reg;
  assign dispense_item = dispense_item_reg;
  assign coin_reject   = coin_reject_reg;
  assign sel_denied    = sel_denied_reg;
  assign dispense      = dispense_reg;
  assign change_valid  = change_valid_reg;
  assign busy          = busy_reg;
  assign coin_ready    = coin_ready_reg;
endmodule

// File: tb/tb_vend_controller.sv
// Scoreboarded random + directed bench for vend_controller against a transaction-level model.
module tb_vend_controller;
  localparam int CW = 7;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] coin_value = '0;
  logic          coin_valid = 1'b0;
  logic          coin_ready, coin_reject;
  logic [1:0]    sel_item = 2'd0;
  logic          sel_valid = 1'b0;
  logic          sel_denied;
  logic          cancel = 1'b0;
  logic [CW-1:0] credit;
  logic          dispense;
  logic [1:0]    dispense_item;
  logic [CW-1:0] change_value;
  logic          change_valid;
  logic          change_ack = 1'b0;
  logic          busy;

  vend_controller #(
    .CURRENCY_WIDTH(CW), .PRICE0(15), .PRICE1(25), .PRICE2(30), .PRICE3(40),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_value(coin_value), .coin_valid(coin_valid), .coin_ready(coin_ready),
    .coin_reject(coin_reject), .sel_item(sel_item), .sel_valid(sel_valid),
    .sel_denied(sel_denied), .cancel(cancel), .credit(credit), .dispense(dispense),
    .dispense_item(dispense_item), .change_value(change_value),
    .change_valid(change_valid), .change_ack(change_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    int cyc; int credit; bit busy; bit coin_ready; bit rej; bit den;
    bit disp; int item; bit cv; int cval;
  } snap_t;

  snap_t exp_q[$];
  int    disp_q[$];
  int    chg_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    price[4] = '{15, 25, 30, 40};

  // Model: the machine's phase is implied by what is owed, not by a state variable.
  int m_credit = 0, m_owed = 0, m_item = 0, m_cnt = 0;
  bit m_disp = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc_cnt, act, exp);
    end
  endfunction

  function automatic void unexpected(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s cycle %0d: DUT event with nothing expected", name, cyc_cnt);
  endfunction

  function automatic void model_reset();
    m_credit = 0; m_owed = 0; m_item = 0; m_cnt = 0; m_disp = 0;
  endfunction

  function automatic snap_t model_step(bit cn, bit sv, int it, bit cv, int val, bit ak);
    snap_t s;
    bit rej, den, collecting, afford, tmo, credited;
    rej = 0; den = 0; tmo = 0; credited = 0;
    if (m_disp) begin
      rej = cv; den = sv; m_disp = 0;
      m_owed = m_credit; m_credit = 0;
      if (m_owed > 0) chg_q.push_back(m_owed);
    end else if (m_owed > 0) begin
      rej = cv; den = sv;
      if (ak) m_owed = 0;
    end else begin
      collecting = (m_credit > 0);
      afford = sv && collecting && (m_credit >= price[it]);
`ifdef VEND_TIMEOUT_EN
      tmo = collecting && (m_cnt == TO - 1);
`endif
      if (collecting && (cn || (tmo && !afford))) begin
        rej = cv; den = sv;
        m_owed = m_credit; m_credit = 0;
        chg_q.push_back(m_owed);
      end else if (afford) begin
        rej = cv;
        m_credit = m_credit - price[it];
        m_disp = 1; m_item = it;
        disp_q.push_back(it);
      end else begin
        den = sv;
        if (cv && val != 0) begin
          if (m_credit + val <= (1 << CW) - 1) begin
            m_credit = m_credit + val; credited = 1; m_cnt = 0;
          end else begin
            rej = 1;
          end
        end
        if (collecting && !credited) m_cnt++;
      end
    end
    s.cyc = 0; s.credit = m_credit;
    s.busy = m_disp || (m_owed > 0) || (m_credit > 0);
    s.coin_ready = !m_disp && (m_owed == 0);
    s.rej = rej; s.den = den; s.disp = m_disp; s.item = m_item;
    s.cv = (m_owed > 0); s.cval = m_owed;
    return s;
  endfunction

  task automatic step(input bit cn, input bit sv, input int it, input bit cv,
                      input int val, input bit ak);
    snap_t s;
    cancel = cn; sel_valid = sv; sel_item = 2'(it);
    coin_valid = cv; coin_value = CW'(val); change_ack = ak;
    s = model_step(cn, sv, it, cv, val, ak);
    s.cyc = cyc_cnt + 1;
    exp_q.push_back(s);
    $display("txn cyc=%0d cancel=%0d sel=%0d/%0d coin=%0d/%0d ack=%0d -> credit=%0d owed=%0d",
             s.cyc, cn, sv, it, cv, val, ak, s.credit, s.cval);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_credit"}, credit, 0);
    chk({tag, "_change_value"}, change_value, 0);
    chk({tag, "_change_valid"}, change_valid, 0);
    chk({tag, "_dispense_item"}, dispense_item, 0);
    chk({tag, "_dispense"}, dispense, 0);
    chk({tag, "_coin_reject"}, coin_reject, 0);
    chk({tag, "_sel_denied"}, sel_denied, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_coin_ready"}, coin_ready, 1);
  endtask

  // Monitor: compares per-cycle status and pops event queues when the DUT presents them.
  initial begin
    bit    cv_prev;
    snap_t e;
    cv_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cv_prev = 0;
        continue;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        e = exp_q.pop_front();
        chk("credit", credit, e.credit);
        chk("busy", busy, e.busy);
        chk("coin_ready", coin_ready, e.coin_ready);
        chk("coin_reject", coin_reject, e.rej);
        chk("sel_denied", sel_denied, e.den);
        chk("dispense", dispense, e.disp);
        chk("change_valid", change_valid, e.cv);
        if (e.disp) chk("dispense_item", dispense_item, e.item);
        if (e.cv) chk("change_value", change_value, e.cval);
      end
      if (dispense) begin
        if (disp_q.size() == 0) unexpected("dispense_event");
        else chk("dispense_event_item", dispense_item, disp_q.pop_front());
      end
      if (change_valid && !cv_prev) begin
        if (chg_q.size() == 0) unexpected("change_event");
        else chk("change_event_value", change_value, chg_q.pop_front());
      end
      cv_prev = change_valid;
    end
  end

  initial begin
    int cn, sv, it, cv, val, ak;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Exact pay
    step(0, 0, 0, 1, 10, 0); step(0, 0, 0, 1, 5, 0); step(0, 1, 0, 0, 0, 0); idle(3);
    // Overpay, change held until ack
    step(0, 0, 0, 1, 25, 0); step(0, 0, 0, 1, 25, 0); step(0, 1, 2, 0, 0, 0);
    idle(5); step(0, 0, 0, 0, 0, 1); idle(2);
    // Short credit, then cancel
    step(0, 0, 0, 1, 10, 0); step(0, 1, 3, 0, 0, 0); idle(1);
    step(1, 0, 0, 0, 0, 0); idle(2); step(0, 0, 0, 0, 0, 1); idle(1);
    // Overflow, then coin colliding with a selection
    step(0, 0, 0, 1, 100, 0); step(0, 0, 0, 1, 30, 0); step(0, 1, 1, 1, 5, 0);
    idle(3); step(0, 0, 0, 0, 0, 1); idle(1);
    // Selection and zero coin in IDLE
    step(0, 1, 0, 1, 0, 0); idle(1);

    // Reset while change is outstanding
    step(0, 0, 0, 1, 25, 0); step(0, 0, 0, 1, 25, 0); step(0, 1, 2, 0, 0, 0); idle(2);
    @(negedge clk);
    #2;
    chk("pre_reset_change_valid", change_valid, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

`ifdef VEND_TIMEOUT_EN
    step(0, 0, 0, 1, 25, 0); idle(10); step(0, 0, 0, 0, 0, 1); idle(1);
`else
    step(0, 0, 0, 1, 25, 0); idle(20); step(1, 0, 0, 0, 0, 0); idle(1);
    step(0, 0, 0, 0, 0, 1); idle(1);
`endif

    for (int i = 0; i < 3000; i++) begin
      cn  = ($urandom_range(0, 99) < 4)  ? 1 : 0;
      sv  = ($urandom_range(0, 99) < 15) ? 1 : 0;
      it  = $urandom_range(0, 3);
      cv  = ($urandom_range(0, 99) < 45) ? 1 : 0;
      val = $urandom_range(1, 60);
      ak  = ($urandom_range(0, 99) < 30) ? 1 : 0;
      if (cv == 1 && cn == 0 && sv == 0 && $urandom_range(0, 19) == 0) val = 0;
      step(cn[0], sv[0], it, cv[0], val, ak[0]);
    end

    repeat (6) step(1, 0, 0, 0, 0, 1);
    idle(2);
    @(negedge clk);
    #1;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("dispense_queue_drained", disp_q.size(), 0);
    chk("change_queue_drained", chg_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
